// File: rtl/karatsuba_seq_mult_16.sv
// Two-requester, round-robin 16x16 unsigned multiplier that time-shares one
// 8x8 Karatsuba core over four passes and returns the product on a valid/ready channel.

module karatsuba_mult_8 (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] p_o
);
   logic [3:0] al, ah, bl, bh;
   logic [4:0] as, bs;
   logic [7:0] z0, z2;
   logic [9:0] zm, z1;

   // One-level Karatsuba on 4-bit halves: three 4/5-bit multiplies instead of four.
   always_comb begin
      al = a_i[3:0];
      ah = a_i[7:4];
      bl = b_i[3:0];
      bh = b_i[7:4];
      as = 5'(al) + 5'(ah);
      bs = 5'(bl) + 5'(bh);
      z0 = 8'(al) * 8'(bl);
      z2 = 8'(ah) * 8'(bh);
      zm = 10'(as) * 10'(bs);
      z1 = zm - 10'(z0) - 10'(z2);
      p_o = (16'(z2) << 8) + (16'(z1) << 4) + 16'(z0);
   end
endmodule

module karatsuba_seq_mult_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_prod,
   output logic        res_id,
   output logic        busy
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [1:0]  pass_q, pass_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic        id_q, id_d, prio_q, prio_d;
   logic [31:0] acc_q, acc_d;
   logic        res_valid_q, res_valid_d;
   logic [31:0] res_prod_q, res_prod_d;
   logic        res_id_q, res_id_d;

   logic        grant_c, any_c, accept_c;
   logic [7:0]  core_a_c, core_b_c;
   logic [15:0] core_p_c;
   logic [31:0] pp_c, sum_c;

   // Lone valid wins outright; contention is settled by the priority pointer.
   assign any_c      = req0_valid | req1_valid;
   assign grant_c    = (req0_valid & req1_valid) ? prio_q : req1_valid;
   assign req0_ready = (state_q == S_IDLE) & any_c & ~grant_c & ~rst;
   assign req1_ready = (state_q == S_IDLE) & any_c &  grant_c & ~rst;
   assign accept_c   = req0_ready | req1_ready;

   // pass[1] selects the a half, pass[0] the b half.
   assign core_a_c = pass_q[1] ? a_q[15:8] : a_q[7:0];
   assign core_b_c = pass_q[0] ? b_q[15:8] : b_q[7:0];

   karatsuba_mult_8 u_core (
      .a_i (core_a_c),
      .b_i (core_b_c),
      .p_o (core_p_c)
   );

   always_comb begin
      case (pass_q)
         2'd0:    pp_c = 32'(core_p_c);
         2'd1,
         2'd2:    pp_c = 32'(core_p_c) << 8;
         default: pp_c = 32'(core_p_c) << 16;
      endcase
      sum_c = (pass_q == 2'd0) ? pp_c : acc_q + pp_c;
   end

   always_comb begin
      state_d     = state_q;
      pass_d      = pass_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      prio_d      = prio_q;
      acc_d       = acc_q;
      res_valid_d = res_valid_q;
      res_prod_d  = res_prod_q;
      res_id_d    = res_id_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               a_d     = grant_c ? req1_a : req0_a;
               b_d     = grant_c ? req1_b : req0_b;
               id_d    = grant_c;
               prio_d  = ~grant_c;
               acc_d   = 32'd0;
               pass_d  = 2'd0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            acc_d  = sum_c;
            pass_d = pass_q + 2'd1;
            if (pass_q == 2'd3) begin
               res_prod_d  = sum_c;
               res_id_d    = id_q;
               res_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (res_valid_q & res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pass_q      <= 2'd0;
         a_q         <= 16'd0;
         b_q         <= 16'd0;
         id_q        <= 1'b0;
         prio_q      <= 1'b0;
         acc_q       <= 32'd0;
         res_valid_q <= 1'b0;
         res_prod_q  <= 32'd0;
         res_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pass_q      <= pass_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         prio_q      <= prio_d;
         acc_q       <= acc_d;
         res_valid_q <= res_valid_d;
         res_prod_q  <= res_prod_d;
         res_id_q    <= res_id_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_prod  = res_prod_q;
   assign res_id    = res_id_q;
   assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_karatsuba_seq_mult_16.sv
// Directed bench for karatsuba_seq_mult_16: vector table plus arbitration,
// backpressure and mid-operation reset sequences.

module tb_karatsuba_seq_mult_16;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        res_valid, res_ready, res_id, busy;
   logic [31:0] res_prod;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        id;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   karatsuba_seq_mult_16 dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_prod   (res_prod),
      .res_id     (res_id),
      .busy       (busy)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one operation on a single requester and complete its result handshake.
   task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
      int n;
      if (id) begin
         req1_a = a; req1_b = b; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_valid = 1'b1;
      end
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 20) begin
         tick();
         n++;
      end
      chk("accept", 32'(id ? req1_ready : req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      n = 0;
      while (!res_valid && n < 20) begin
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'd4);
      chk("prod", res_prod, exp);
      chk("id", 32'(res_id), 32'(id));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("idle_after_handshake", {30'd0, res_valid, busy}, 32'd0);
   endtask

   initial begin
      int n;
      vecs[0] = '{1'b0, 16'h1234, 16'h5678, 32'h0626_0060};
      vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      vecs[2] = '{1'b0, 16'h0000, 16'hABCD, 32'h0000_0000};
      vecs[3] = '{1'b1, 16'h00FF, 16'hFF00, 32'h00FE_0100};
      vecs[4] = '{1'b0, 16'h0003, 16'h0005, 32'h0000_000F};
      vecs[5] = '{1'b1, 16'h0100, 16'h0100, 32'h0001_0000};
      vecs[6] = '{1'b0, 16'hFFFF, 16'h0001, 32'h0000_FFFF};
      vecs[7] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000};

      rst = 1'b1;
      res_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222;
      req1_valid = 1'b1; req1_a = 16'h3333; req1_b = 16'h4444;

      // Reset with both requesters pending.
      tick();
      tick();
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_prod", res_prod, 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      chk("first_grant_r0", 32'(req0_ready), 32'd1);
      chk("first_grant_r1", 32'(req1_ready), 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // Both held valid: strict alternation starting with requester 0, 6 cycles apart.
      req0_a = 16'h0003; req0_b = 16'h0005; req0_valid = 1'b1;
      req1_a = 16'h0100; req1_b = 16'h0100; req1_valid = 1'b1;
      res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!res_valid && n < 30) begin
            tick();
            n++;
         end
         chk("arb_spacing", 32'(n), 32'd5);
         chk("arb_id", 32'(res_id), 32'(k % 2));
         chk("arb_prod", res_prod, (k % 2 == 0) ? 32'h0000_000F : 32'h0001_0000);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Backpressure: result held while the other requester waits.
      req0_a = 16'h00FF; req0_b = 16'hFF00; req0_valid = 1'b1;
      #1;
      chk("bp_accept", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_a = 16'h0100; req1_b = 16'h0100; req1_valid = 1'b1;
      n = 0;
      while (!res_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_latency", 32'(n), 32'd4);
      for (int c = 0; c < 10; c++) begin
         chk("bp_hold_prod", res_prod, 32'h00FE_0100);
         chk("bp_hold_ctl", {27'd0, res_valid, res_id, req0_ready, req1_ready, busy},
             {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("bp_post_valid", 32'(res_valid), 32'd0);
      chk("bp_next_ready", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      chk("bp_next_busy", 32'(busy), 32'd1);
      n = 0;
      while (!res_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_next_latency", 32'(n), 32'd4);
      chk("bp_next_prod", res_prod, 32'h0001_0000);
      chk("bp_next_id", 32'(res_id), 32'd1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Reset during pass 2 abandons the operation.
      req0_a = 16'h1234; req0_b = 16'h5678; req0_valid = 1'b1;
      #1;
      chk("mid_accept", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_idle", {30'd0, res_valid, busy}, 32'd0);
      n = 0;
      for (int c = 0; c < 8; c++) begin
         if (res_valid || busy) n++;
         tick();
      end
      chk("mid_rst_no_result", 32'(n), 32'd0);
      do_op(1'b1, 16'h1234, 16'h5678, 32'h0626_0060);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
